// File: rtl/gpio_ad_dreg.sv
// Memory-mapped GPIO port: two input words, two write-enabled output registers,
// a 2-bit word address decoder and a combinational 4:1 read multiplexer.
module gpio_ad_dreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       A,
  input  logic             WE,
  input  logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] gpI1,
  input  logic [WIDTH-1:0] gpI2,
  output logic [WIDTH-1:0] RD,
  output logic [WIDTH-1:0] gpO1,
  output logic [WIDTH-1:0] gpO2
);

  logic             we1_s;
  logic             we2_s;
  logic [1:0]       rdsel_s;
  logic [WIDTH-1:0] gpo1_r;
  logic [WIDTH-1:0] gpo2_r;
  logic [WIDTH-1:0] rd_s;

  // Address decode: one-hot write enables for the two output registers.
  always_comb begin
    we1_s   = 1'b0;
    we2_s   = 1'b0;
    rdsel_s = A;
    case (A)
      2'b10: begin
        we1_s = WE;
        we2_s = 1'b0;
      end
      2'b11: begin
        we1_s = 1'b0;
        we2_s = WE;
      end
      default: begin
        we1_s = 1'b0;
        we2_s = 1'b0;
      end
    endcase
  end

  // Output register 1: cleared asynchronously, loaded from WD when selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpo1_r <= {WIDTH{1'b0}};
    end else if (we1_s) begin
      gpo1_r <= WD;
    end else begin
      gpo1_r <= gpo1_r;
    end
  end

  // Output register 2: cleared asynchronously, loaded from WD when selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpo2_r <= {WIDTH{1'b0}};
    end else if (we2_s) begin
      gpo2_r <= WD;
    end else begin
      gpo2_r <= gpo2_r;
    end
  end

  // Zero-latency read mux; register reads return the pre-write value in a write cycle.
  always_comb begin
    rd_s = {WIDTH{1'b0}};
    case (rdsel_s)
      2'b00:   rd_s = gpI1;
      2'b01:   rd_s = gpI2;
      2'b10:   rd_s = gpo1_r;
      2'b11:   rd_s = gpo2_r;
      default: rd_s = {WIDTH{1'b0}};
    endcase
  end

  assign RD   = rd_s;
  assign gpO1 = gpo1_r;
  assign gpO2 = gpo2_r;

endmodule

// File: tb/tb_gpio_ad_dreg.sv
// Self-checking bench for gpio_ad_dreg: vector table plus hand-written reset
// sequences, with expectations routed through a scoreboard queue.
module tb_gpio_ad_dreg;

  logic        clk;
  logic        rst;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] gpI1;
  logic [31:0] gpI2;
  logic [31:0] RD;
  logic [31:0] gpO1;
  logic [31:0] gpO2;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] gi1;
    logic [31:0] gi2;
    logic [31:0] exp_rd;
    logic [31:0] exp_o1;
    logic [31:0] exp_o2;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  gpio_ad_dreg #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .WE   (WE),
    .WD   (WD),
    .gpI1 (gpI1),
    .gpI2 (gpI2),
    .RD   (RD),
    .gpO1 (gpO1),
    .gpO2 (gpO2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: actual=%08h required=<queued expectation>", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: actual=%08h required=%08h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic apply_vec(input int idx);
    @(negedge clk);
    A    = vecs[idx].a;
    WE   = vecs[idx].we;
    WD   = vecs[idx].wd;
    gpI1 = vecs[idx].gi1;
    gpI2 = vecs[idx].gi2;
    sb_push($sformatf("vec%0d_rd", idx), vecs[idx].exp_rd);
    sb_push($sformatf("vec%0d_gpO1", idx), vecs[idx].exp_o1);
    sb_push($sformatf("vec%0d_gpO2", idx), vecs[idx].exp_o2);
    #1;
    sb_check(RD);
    @(posedge clk);
    #1;
    sb_check(gpO1);
    sb_check(gpO2);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    A  = a;
    WE = 1'b1;
    WD = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          a      we    wd            gi1           gi2           exp_rd        exp_o1        exp_o2
    vecs[0]  = '{2'd2, 1'b1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 32'h12345678, 32'h00000000};
    vecs[1]  = '{2'd3, 1'b1, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 32'h00000000, 32'h12345678, 32'hCAFEF00D};
    vecs[2]  = '{2'd2, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h12345678, 32'h12345678, 32'hCAFEF00D};
    vecs[3]  = '{2'd3, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
    vecs[4]  = '{2'd0, 1'b0, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h12345678, 32'hCAFEF00D};
    vecs[5]  = '{2'd1, 1'b0, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h12345678, 32'hCAFEF00D};
    vecs[6]  = '{2'd0, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h12345678, 32'hCAFEF00D};
    vecs[7]  = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h12345678, 32'hCAFEF00D};
    vecs[8]  = '{2'd2, 1'b0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h12345678, 32'hCAFEF00D};
    vecs[9]  = '{2'd2, 1'b1, 32'h00000001, 32'h00000000, 32'h00000000, 32'h12345678, 32'h00000001, 32'hCAFEF00D};
    vecs[10] = '{2'd2, 1'b1, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000002, 32'hCAFEF00D};
    vecs[11] = '{2'd3, 1'b1, 32'h00000003, 32'h00000000, 32'h00000000, 32'hCAFEF00D, 32'h00000002, 32'h00000003};
    vecs[12] = '{2'd3, 1'b1, 32'h80000001, 32'h00000000, 32'h00000000, 32'h00000003, 32'h00000002, 32'h80000001};
    vecs[13] = '{2'd2, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000002, 32'h00000002, 32'h80000001};

    rst  = 1'b0;
    A    = 2'd2;
    WE   = 1'b0;
    WD   = 32'h00000000;
    gpI1 = 32'h00000000;
    gpI2 = 32'h00000000;

    // Reset state, observed before any clock edge.
    #1;
    sb_push("reset_gpO1", 32'h00000000);
    sb_push("reset_gpO2", 32'h00000000);
    sb_push("reset_rd", 32'h00000000);
    sb_check(gpO1);
    sb_check(gpO2);
    sb_check(RD);

    @(negedge clk);
    rst = 1'b1;

    // Load both registers, then assert reset mid-cycle: clears without a clock edge.
    write_reg(2'd2, 32'hDEADBEEF);
    write_reg(2'd3, 32'hDEADBEEF);
    sb_push("preload_gpO1", 32'hDEADBEEF);
    sb_push("preload_gpO2", 32'hDEADBEEF);
    sb_check(gpO1);
    sb_check(gpO2);
    @(negedge clk);
    A = 2'd2;
    #2;
    rst = 1'b0;
    #1;
    sb_push("async_rst_gpO1", 32'h00000000);
    sb_push("async_rst_gpO2", 32'h00000000);
    sb_push("async_rst_rd", 32'h00000000);
    sb_check(gpO1);
    sb_check(gpO2);
    sb_check(RD);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply_vec(i);
    end

    // Reset held across a write edge: reset wins, then the next edge writes.
    @(negedge clk);
    rst = 1'b0;
    A   = 2'd2;
    WE  = 1'b1;
    WD  = 32'h11111111;
    @(posedge clk);
    #1;
    sb_push("rst_write_gpO1", 32'h00000000);
    sb_push("rst_write_gpO2", 32'h00000000);
    sb_check(gpO1);
    sb_check(gpO2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_push("post_rst_write_gpO1", 32'h11111111);
    sb_push("post_rst_write_gpO2", 32'h00000000);
    sb_push("post_rst_write_rd", 32'h11111111);
    sb_check(gpO1);
    sb_check(gpO2);
    sb_check(RD);
    WE = 1'b0;

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: actual=%0d required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ad_dreg.md
# gpio_ad_dreg

Memory-mapped general-purpose I/O port with two input words and two output registers, selected by a 2-bit word address. It sits on the processor's peripheral bus next to data memory, and the system address decoder drives its write strobe. It combines three parts:
- an address decoder (gpio_ad function) that produces per-register write enables and a read select;
- two enabled data registers (dreg_en function) that hold the output words;
- a 4:1 read multiplexer that drives the read-data bus.

## Interface
Parameters:
- WIDTH, 32, data width of every data port and register.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset: rst=0 clears state immediately, independent of clk.
- A  input  2  word address within the GPIO block.
- WE  input  1  bus write strobe, active-high, qualified by A.
- WD  input  WIDTH  bus write data.
- gpI1  input  WIDTH  general-purpose input word 1.
- gpI2  input  WIDTH  general-purpose input word 2.
- RD  output  WIDTH  bus read data.
- gpO1  output  WIDTH  general-purpose output register 1.
- gpO2  output  WIDTH  general-purpose output register 2.

## Operation
Address map:
- A=00: read gpI1; writes ignored.
- A=01: read gpI2; writes ignored.
- A=10: read gpO1; a write loads gpO1.
- A=11: read gpO2; a write loads gpO2.

Decoder (combinational):
- WE1 = WE & (A==2'b10).
- WE2 = WE & (A==2'b11).
- RdSel = A.
- At most one of WE1 and WE2 is high at any time.

Output registers (dreg_en behaviour):
- While rst=0: q=0.
- Otherwise, on the rising edge of clk: if en=1 then q<=d, else q holds.
- gpO1 register: d=WD, en=WE1.
- gpO2 register: d=WD, en=WE2.

Read mux (combinational):
- RdSel 0 -> gpI1, 1 -> gpI2, 2 -> gpO1, 3 -> gpO2.
- Reading gpO1 or gpO2 returns the current register value. This is the pre-write value during the cycle in which a write to that register occurs.

Width rules:
- All data paths are WIDTH bits with no truncation or extension.
- WD is stored bit-exact.

## Timing
- Reset:
  - rst falling to 0 clears gpO1 and gpO2 to 0 immediately, without waiting for a clock edge.
  - RD follows combinationally; with A=10 or 11 during reset, RD=0.
- Reset mid-write: if rst=0 coincides with a clock edge while WE1 or WE2 is high, reset wins and the register stays 0.
- Reset release: the first write takes effect on the first rising edge of clk with rst=1.
- Write latency:
  - Register output updates at the rising edge where WE and A select it.
  - The new value is visible on gpOx, and on RD when A selects it, after that edge: one-cycle write latency.
- Read latency: zero cycles. RD is purely combinational from A, gpI1, gpI2 and the register outputs.
- Writes to A=00 or 01 have no effect on any state.
- WE=0 never modifies state, whatever A is.
- Back-to-back writes to the same register on consecutive cycles each take effect in their own cycle; the last write wins.
- There is no handshake; WE is sampled only at the rising edge of clk.

## Test plan
- Reset: drive rst=0 with gpO1 and gpO2 previously holding 0xDEADBEEF -> both read 0 before any clock edge; with A=10, RD=0.
- Write/read-back: after reset release, A=10, WE=1, WD=0x12345678 for one edge -> gpO1=0x12345678 and gpO2 unchanged at 0. Then A=11, WD=0xCAFEF00D -> gpO2=0xCAFEF00D. Reading A=10 and A=11 with WE=0 returns those values.
- Input read: gpI1=0xA5A5A5A5, gpI2=0x5A5A5A5A, WE=0 -> RD=0xA5A5A5A5 at A=00 and RD=0x5A5A5A5A at A=01, in the same cycle the address changes.
- Ignored writes:
  - A=00 or 01 with WE=1, WD=0xFFFFFFFF -> gpO1 and gpO2 unchanged.
  - A=10 with WE=0 and WD=0xFFFFFFFF -> gpO1 unchanged.
- Reset during write: A=10, WE=1, WD=0x11111111 with rst=0 asserted before the edge -> gpO1 stays 0. With rst=1 at the next edge -> gpO1=0x11111111.
- Read-during-write: gpO1=0x1, then A=10, WE=1, WD=0x2 -> RD=0x1 before the edge and RD=0x2 after it.
